uart_block_rx: RTL and testbench
================================

UART_BLOCK_RX -- requirements
Module: uart_block_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range is 4 or more, even.
REQ-002 SHALL have parameter BYTES_PER_BLOCK, default 16: bytes assembled per block; the data_out width is fixed at 8*BYTES_PER_BLOCK = 128.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en_rx, input, 1 bit: receive enable, sampled only in IDLE.
REQ-006 SHALL have port rx_serial, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port data_out, output, 128 bits: last completed ciphertext block, handed to the decryption stage.
REQ-008 SHALL have port u_rx_done, output, 1 bit: one-cycle pulse when data_out is updated.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit (or bad parity; see REQ-024).
REQ-010 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE, or the byte count is non-zero.

Function
REQ-011 SHALL pass rx_serial through a 2-flop synchronizer; all references to "line" below mean the synchronized value.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY per REQ-024).
- IDLE -> START: en_rx=1 and a line falling edge.
- START: on the cycle at which the bit counter reaches CLKS_PER_BIT/2-1, line=0 -> DATA; line=1 -> IDLE (glitch, no error, byte count kept).
- DATA: 8 samples, one every CLKS_PER_BIT cycles; first bit shifted into byte bit 0.
- STOP: one sample after a further CLKS_PER_BIT cycles; then -> IDLE.
REQ-013 SHALL, on stop=1, store the byte into the block shift register; the first byte of a block lands in data_out[127:120] and the last in [7:0].
REQ-014 SHALL, when the good byte completes the block (byte count 15), load data_out and pulse u_rx_done on the next clk edge; byte count wraps to 0.
REQ-015 SHALL, on stop=0, discard the byte, pulse frame_err, and reset the byte count to 0, aborting the partial block; data_out is unchanged.
REQ-016 SHALL hold data_out stable between u_rx_done pulses; partial blocks are never visible.
REQ-017 SHALL ignore en_rx deassertion mid-byte; the current byte completes. Partial block progress is kept across en_rx low.
REQ-018 SHALL never assert u_rx_done and frame_err in the same cycle.
REQ-019 SHALL accept back-to-back frames: the start edge of the next frame may occur on the cycle IDLE is re-entered.

Reset
REQ-020 SHALL, while reset=0, asynchronously force state=IDLE, data_out=0, u_rx_done=0, frame_err=0, busy=0, byte count=0, all counters=0, and synchronizer flops=1.
REQ-021 SHALL, on reset mid-frame or mid-block, discard all partial data; after release it receives only on a fresh start edge.

Configuration
REQ-022 SHALL use macro UART_RX_PARITY_EN.
REQ-023 SHALL, without UART_RX_PARITY_EN, use frames of 10 bits (8N1), with STOP directly after DATA.
REQ-024 SHALL, with UART_RX_PARITY_EN, add a PARITY state between DATA and STOP that samples one even-parity bit. On a mismatch it treats the frame as REQ-015 (frame_err pulse, block abort), even if stop=1.

Verification (CLKS_PER_BIT=16)
REQ-025 SHALL cover: 16 clean frames carrying bytes 0x00..0x0F -> one u_rx_done pulse, with data_out=0x000102030405060708090A0B0C0D0E0F.
REQ-026 SHALL cover: a 5-cycle low glitch on the idle line -> no frame_err, no u_rx_done, busy returns to 0.
REQ-027 SHALL cover: byte 7 sent with stop=0, then 16 clean bytes 0xA5 -> frame_err pulse once, then data_out=all 0xA5 with one u_rx_done.
REQ-028 SHALL cover: reset asserted mid-DATA of byte 10, then 16 clean bytes -> exactly one u_rx_done, with the new block only.
REQ-029 SHALL cover: en_rx=0 while 16 frames are sent -> busy=0 throughout, no pulses, data_out unchanged.
REQ-030 SHALL cover, with UART_RX_PARITY_EN: byte 0x01 sent with parity=0 -> frame_err pulse and byte count=0.

Source files
------------

// File: rtl/uart_block_rx.sv
// rtl/uart_block_rx.sv - 8N1 UART receiver assembling bytes into blocks; optional even parity via UART_RX_PARITY_EN
module uart_block_rx #(
    parameter int CLKS_PER_BIT    = 16,
    parameter int BYTES_PER_BLOCK = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en_rx,
    input  logic                         rx_serial,
    output logic [8*BYTES_PER_BLOCK-1:0] data_out,
    output logic                         u_rx_done,
    output logic                         frame_err,
    output logic                         busy
);

    localparam int BLK_W = 8 * BYTES_PER_BLOCK;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int BCW   = $clog2(BYTES_PER_BLOCK);

    localparam logic [CW-1:0]  HALF_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_BLOCK - 1);
    localparam logic [BCW-1:0] BYTE_ONE  = BCW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q;
    logic               sync1_q;
    logic               sync2_q;
    logic               line_prev_q;
    logic [CW-1:0]      clk_cnt_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic [BLK_W-1:0]   block_q;
    logic [BCW-1:0]     byte_cnt_q;
    logic [BLK_W-1:0]   data_out_q;
    logic               done_q;
    logic               err_q;
    logic               line;
    logic               start_edge;
    logic               frame_ok;

    assign line       = sync2_q;
    assign start_edge = line_prev_q & ~line;

`ifdef UART_RX_PARITY_EN
    logic par_err_q;
    assign frame_ok = line & ~par_err_q;
`else
    assign frame_ok = line;
`endif

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync1_q     <= rx_serial;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
        end
    end

    // Frame FSM: mid-bit sampling, byte assembly into the block register, pulse generation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            block_q    <= '0;
            byte_cnt_q <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    clk_cnt_q <= '0;
                    if (en_rx && start_edge) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt_q == HALF_CNT) begin
                        // A line already back high at mid start bit is a glitch, not a frame.
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= line ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
                        par_err_q <= 1'b0;
`endif
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (clk_cnt_q == FULL_CNT) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {line, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (clk_cnt_q == FULL_CNT) begin
                        clk_cnt_q <= '0;
                        par_err_q <= line ^ (^shift_q);
                        state_q   <= S_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (clk_cnt_q == FULL_CNT) begin
                        clk_cnt_q <= '0;
                        state_q   <= S_IDLE;
                        if (frame_ok) begin
                            block_q <= {block_q[BLK_W-9:0], shift_q};
                            if (byte_cnt_q == LAST_BYTE) begin
                                data_out_q <= {block_q[BLK_W-9:0], shift_q};
                                done_q     <= 1'b1;
                                byte_cnt_q <= '0;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + BYTE_ONE;
                            end
                        end else begin
                            // Bad frame aborts the whole partial block; data_out keeps the last good block.
                            err_q      <= 1'b1;
                            byte_cnt_q <= '0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    clk_cnt_q <= '0;
                end
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign u_rx_done = done_q;
    assign frame_err = err_q;
    assign busy      = (state_q != S_IDLE) || (byte_cnt_q != '0);

endmodule

// File: tb/tb_uart_block_rx.sv
// tb/tb_uart_block_rx.sv - scoreboard bench for uart_block_rx with a byte-queue reference model
module tb_uart_block_rx;

    localparam int CPB = 16;
    localparam int BPB = 16;

    logic           clk;
    logic           reset;
    logic           en_rx;
    logic           rx_serial;
    logic [127:0]   data_out;
    logic           u_rx_done;
    logic           frame_err;
    logic           busy;

    typedef struct {
        bit           is_err;
        logic [127:0] data;
    } exp_t;

    exp_t           exp_q[$];
    logic [7:0]     blk_q[$];
    logic [127:0]   mdl_last;
    logic [127:0]   exp_cur;
    exp_t           e;
    int             compared;
    int             errors;
    int             stable_bad;
    bit             watch_busy;
    bit             busy_seen;

    uart_block_rx #(
        .CLKS_PER_BIT    (CPB),
        .BYTES_PER_BLOCK (BPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en_rx     (en_rx),
        .rx_serial (rx_serial),
        .data_out  (data_out),
        .u_rx_done (u_rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        compared++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference model: a frame received while enabled either extends the block or aborts it.
    task automatic mdl_frame(input logic [7:0] b, input bit good);
        logic [127:0] v;
        exp_t x;
        if (!en_rx) return;
        if (good) begin
            blk_q.push_back(b);
            if (blk_q.size() == BPB) begin
                v = '0;
                for (int i = 0; i < BPB; i++) v = v + (128'(blk_q[i]) << (8 * (BPB - 1 - i)));
                x.is_err = 1'b0;
                x.data   = v;
                exp_q.push_back(x);
                mdl_last = v;
                blk_q.delete();
            end
        end else begin
            blk_q.delete();
            x.is_err = 1'b1;
            x.data   = mdl_last;
            exp_q.push_back(x);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_serial = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_bad);
        mdl_frame(b, stop_bit && !par_bad);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_bad);
`endif
        drive_bit(stop_bit);
        if (!stop_bit) begin
            rx_serial = 1'b1;
            repeat (2 * CPB) @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops the scoreboard on every pulse and tracks data_out stability between pulses.
    always @(negedge clk) begin
        if (!reset) exp_cur = '0;
        if (u_rx_done && frame_err) begin
            compared++;
            errors++;
            $display("FAIL both_pulses: done=%b err=%b expected only one", u_rx_done, frame_err);
        end
        if (u_rx_done) begin
            compared++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got data %h expected no pulse", data_out);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err || data_out !== e.data) begin
                    errors++;
                    $display("FAIL done_data: got done data %h expected err=%b data %h", data_out, e.is_err, e.data);
                end
                exp_cur = e.data;
            end
        end else if (frame_err) begin
            compared++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_err: got frame_err=1 expected no pulse");
            end else begin
                e = exp_q.pop_front();
                if (!e.is_err || data_out !== e.data) begin
                    errors++;
                    $display("FAIL frame_err_event: got err with data %h expected err=%b data %h", data_out, e.is_err, e.data);
                end
            end
        end else if (reset && data_out !== exp_cur) begin
            stable_bad++;
        end
        if (watch_busy && busy) busy_seen = 1'b1;
    end

    initial begin
        logic [7:0] b;
        bit bad;
        compared   = 0;
        errors     = 0;
        stable_bad = 0;
        watch_busy = 1'b0;
        busy_seen  = 1'b0;
        mdl_last   = '0;
        exp_cur    = '0;
        reset      = 1'b0;
        en_rx      = 1'b1;
        rx_serial  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_data_out", data_out, '0);
        check("reset_done", 128'(u_rx_done), '0);
        check("reset_frame_err", 128'(frame_err), '0);
        check("reset_busy", 128'(busy), '0);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Sixteen clean frames 0x00..0x0F
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("block_0f", data_out, 128'h000102030405060708090A0B0C0D0E0F);

        // Five-cycle glitch on an idle line
        rx_serial = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx_serial = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_busy", 128'(busy), '0);

        // Bad stop bit on byte 7, then sixteen 0xA5
        send_frame(8'h07, 1'b0, 1'b0);
        check("after_err_busy", 128'(busy), '0);
        for (int i = 0; i < 16; i++) send_frame(8'hA5, 1'b1, 1'b0);
        check("block_a5", data_out, {16{8'hA5}});

        // Reset in the middle of DATA of byte 10
        for (int i = 0; i < 10; i++) send_frame(8'($urandom), 1'b1, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        reset     = 1'b0;
        rx_serial = 1'b1;
        blk_q.delete();
        mdl_last  = '0;
        #2;
        check("midreset_data_out", data_out, '0);
        check("midreset_busy", 128'(busy), '0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send_frame(8'(8'h30 + i), 1'b1, 1'b0);
        check("post_reset_block", data_out, mdl_last);

        // Receiver disabled for a whole block
        en_rx      = 1'b0;
        busy_seen  = 1'b0;
        watch_busy = 1'b1;
        for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, 1'b0);
        watch_busy = 1'b0;
        check("disabled_busy_seen", 128'(busy_seen), '0);
        check("disabled_data_out", data_out, mdl_last);
        en_rx = 1'b1;

        // Partial block survives en_rx low between frames
        for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1, 1'b0);
        en_rx = 1'b0;
        for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1, 1'b0);
        check("paused_busy", 128'(busy), 128'(1));
        en_rx = 1'b1;
        for (int i = 0; i < 11; i++) send_frame(8'($urandom), 1'b1, 1'b0);
        check("resumed_block", data_out, mdl_last);

`ifdef UART_RX_PARITY_EN
        // Byte 0x01 with parity bit 0 aborts the partial block
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1);
        check("parity_err_busy", 128'(busy), '0);
`endif

        // Random bytes with occasional bad stop bits, then a clean block
        for (int i = 0; i < 48; i++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, !bad, 1'b0);
        end
        for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, 1'b0);
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("final_block", data_out, mdl_last);
        check("scoreboard_drained", 128'(exp_q.size()), '0);
        check("data_out_stable", 128'(stable_bad), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule
